// File: rtl/seven_seg_bcd_display.sv
// Multi-digit seven-segment controller: a sequential double-dabble engine converts a
// binary value to BCD, then drives active-low segment buses with blanking, blink and dp.
module seven_seg_bcd_display #(
  parameter int NUM_DIGITS = 6,
  parameter int VALUE_W    = 20,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VALUE_W-1:0]      value_in,
  input  logic                    load,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    busy,
  output logic                    overflow,
  output logic [8*NUM_DIGITS-1:0] hex_out
);

  localparam int BCD_W   = 4*NUM_DIGITS + 4;
  localparam int CNT_W   = $clog2(VALUE_W + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(VALUE_W - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

  function automatic logic [6:0] glyphSegments(input logic [3:0] g);
    case (g)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h77;
      4'hB:    return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                         r_state, w_nextState;
  logic [VALUE_W-1:0]             r_bin;
  logic [BCD_W-1:0]               r_bcd;
  logic [BCD_W-1:0]               w_bcdAdj;
  logic [CNT_W-1:0]               r_bitCnt;
  logic                           r_lz;
  logic                           r_ovfPend;
  logic                           r_overflow;
  logic                           w_ovfIn;
  logic                           w_leading;
  logic [NUM_DIGITS-1:0][3:0]     r_digit;
  logic [NUM_DIGITS-1:0][3:0]     w_commitDigit;
  logic [BLINK_W-1:0]             r_blinkCnt;
  logic                           r_phase;
  logic [8*NUM_DIGITS-1:0]        r_hex;
  logic [8*NUM_DIGITS-1:0]        w_hexNext;

  assign w_ovfIn  = (64'(value_in) >= LIMIT);
  assign busy     = (r_state != IDLE);
  assign overflow = r_overflow;
  assign hex_out  = r_hex;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (load) w_nextState = SHIFT;
      SHIFT:   if (r_bitCnt == LAST_BIT) w_nextState = COMMIT;
      COMMIT:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_bcdAdj = r_bcd;
    for (int i = 0; i < BCD_W/4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Walk from the top digit down; zeros stay blank until the first non-zero digit.
  always_comb begin
    w_commitDigit = '0;
    w_leading     = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      if (r_ovfPend) begin
        w_commitDigit[i] = 4'hB;
      end else if (r_lz && w_leading && (i != 0) && (r_bcd[4*i +: 4] == 4'd0)) begin
        w_commitDigit[i] = 4'hF;
      end else begin
        w_commitDigit[i] = r_bcd[4*i +: 4];
        w_leading        = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_bitCnt   <= '0;
      r_lz       <= 1'b0;
      r_ovfPend  <= 1'b0;
      r_overflow <= 1'b0;
      r_digit    <= {NUM_DIGITS{4'hF}};
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_bin     <= value_in;
            r_bcd     <= '0;
            r_bitCnt  <= '0;
            r_lz      <= lz_blank;
            r_ovfPend <= w_ovfIn;
          end
        end
        SHIFT: begin
          // A bit falling out of the guard nibble implies overflow was already flagged.
          r_bcd     <= {w_bcdAdj[BCD_W-2:0], r_bin[VALUE_W-1]};
          r_bin     <= {r_bin[VALUE_W-2:0], 1'b0};
          r_bitCnt  <= r_bitCnt + 1'b1;
          r_ovfPend <= r_ovfPend | w_bcdAdj[BCD_W-1];
        end
        COMMIT: begin
          r_digit    <= w_commitDigit;
          r_overflow <= r_ovfPend;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (r_blinkCnt == BLINK_MAX) begin
      r_blinkCnt <= '0;
      r_phase    <= ~r_phase;
    end else begin
      r_blinkCnt <= r_blinkCnt + 1'b1;
    end
  end

  always_comb begin
    w_hexNext = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_phase && blink_mask[i]) w_hexNext[8*i +: 8] = 8'hFF;
      else w_hexNext[8*i +: 8] = {~dp_mask[i], glyphSegments(r_digit[i])};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_hex <= '1;
    else     r_hex <= w_hexNext;
  end

endmodule

// File: tb/tb_seven_seg_bcd_display.sv
// Bench for seven_seg_bcd_display: fixed vectors, random loads against a decimal-arithmetic
// display model, plus blink, ignored-load and mid-conversion reset sequences.
module tb_seven_seg_bcd_display;

  localparam int ND = 6;
  localparam int VW = 20;
  localparam int BD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [VW-1:0]   value_in = '0;
  logic            load = 1'b0;
  logic            lz_blank = 1'b0;
  logic [ND-1:0]   blink_mask = '0;
  logic [ND-1:0]   dp_mask = '0;
  logic            busy;
  logic            overflow;
  logic [8*ND-1:0] hex_out;

  int compared   = 0;
  int mismatched = 0;
  int edgeCnt    = 0;

  logic mValid = 1'b0;
  int   mValue = 0;
  logic mLz    = 1'b0;

  logic [7:0] digitPat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    int          value;
    logic        lz;
    logic [47:0] expHex;
    logic        expOvf;
  } vec_t;

  vec_t vecs [10];

  seven_seg_bcd_display #(.NUM_DIGITS(ND), .VALUE_W(VW), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .lz_blank(lz_blank),
    .blink_mask(blink_mask), .dp_mask(dp_mask), .busy(busy), .overflow(overflow),
    .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) edgeCnt <= 0;
    else     edgeCnt <= edgeCnt + 1;
  end

  function automatic int pow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  // Display is registered, so the phase seen now is the one from the previous cycle.
  function automatic logic modelPhase();
    if (edgeCnt == 0) return 1'b0;
    return (((edgeCnt - 1) / BD) % 2) == 1;
  endfunction

  function automatic logic [47:0] modelHex(input logic valid, input int value, input logic lz,
                                           input logic [ND-1:0] bm, input logic [ND-1:0] dm,
                                           input logic phase);
    logic [47:0] h;
    logic [7:0]  b;
    int          p;
    h = '1;
    for (int i = 0; i < ND; i++) begin
      p = pow10(i);
      if (!valid)                         b = 8'hFF;
      else if (value >= pow10(ND))        b = 8'hBF;
      else if (lz && i > 0 && value < p)  b = 8'hFF;
      else                                b = digitPat[(value / p) % 10];
      b[7] = ~dm[i];
      if (phase && bm[i]) b = 8'hFF;
      h[8*i +: 8] = b;
    end
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    check(name, 64'(hex_out), 64'(modelHex(mValid, mValue, mLz, blink_mask, dp_mask, modelPhase())));
  endtask

  // Pulses load for one cycle; an optional second load is raised at busy sample injectAt.
  task automatic applyStimulus(input int v, input logic lz, input int injectAt, input int injectVal,
                               output int busyCycles);
    value_in   = VW'(v);
    lz_blank   = lz;
    load       = 1'b1;
    tick();
    load       = 1'b0;
    busyCycles = 0;
    while (busy && busyCycles < 100) begin
      busyCycles++;
      checkOutput("heldDuringBusy");
      load = (busyCycles == injectAt);
      if (load) value_in = VW'(injectVal);
      tick();
    end
    load = 1'b0;
    checkOutput("heldAtCommit");
    mValid = 1'b1;
    mValue = v;
    mLz    = lz;
    check("overflow", 64'(overflow), 64'(v >= pow10(ND)));
    tick();
  endtask

  initial begin
    int cycles;

    vecs[0] = '{1234,    1'b1, 48'hFFFF_F9A4_B099, 1'b0};
    vecs[1] = '{1234,    1'b0, 48'hC0C0_F9A4_B099, 1'b0};
    vecs[2] = '{0,       1'b1, 48'hFFFF_FFFF_FFC0, 1'b0};
    vecs[3] = '{1000000, 1'b1, 48'hBFBF_BFBF_BFBF, 1'b1};
    vecs[4] = '{999999,  1'b1, 48'h9090_9090_9090, 1'b0};
    vecs[5] = '{1048575, 1'b0, 48'hBFBF_BFBF_BFBF, 1'b1};
    vecs[6] = '{100000,  1'b1, 48'hF9C0_C0C0_C0C0, 1'b0};
    vecs[7] = '{7,       1'b1, 48'hFFFF_FFFF_FFF8, 1'b0};
    vecs[8] = '{0,       1'b0, 48'hC0C0_C0C0_C0C0, 1'b0};
    vecs[9] = '{50607,   1'b1, 48'hFF92_C082_C0F8, 1'b0};

    tick();
    tick();
    check("resetHex", 64'(hex_out), 64'(48'hFFFF_FFFF_FFFF));
    check("resetBusy", 64'(busy), 64'd0);
    check("resetOverflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("idleAfterReset");

    for (int n = 0; n < 10; n++) begin
      applyStimulus(vecs[n].value, vecs[n].lz, -1, 0, cycles);
      check($sformatf("busyCycles[%0d]", n), 64'(cycles), 64'd21);
      check($sformatf("vecHex[%0d]", n), 64'(hex_out), 64'(vecs[n].expHex));
      check($sformatf("vecOvf[%0d]", n), 64'(overflow), 64'(vecs[n].expOvf));
      checkOutput($sformatf("vecModel[%0d]", n));
    end

    blink_mask = 6'b000001;
    dp_mask    = 6'b000010;
    applyStimulus(1234, 1'b1, -1, 0, cycles);
    for (int c = 0; c < 16; c++) begin
      checkOutput("blinkModel");
      check("blinkDigit1", 64'(hex_out[15:8]), 64'h30);
      check("blinkDigit0", 64'(hex_out[7:0]), modelPhase() ? 64'hFF : 64'h99);
      tick();
    end

    for (int r = 0; r < 24; r++) begin
      int   v;
      logic lz;
      v          = int'($urandom_range(0, (1 << VW) - 1));
      lz         = 1'($urandom);
      blink_mask = ND'($urandom);
      dp_mask    = ND'($urandom);
      applyStimulus(v, lz, -1, 0, cycles);
      check("randBusyCycles", 64'(cycles), 64'd21);
      for (int c = 0; c < 3; c++) begin
        checkOutput("randModel");
        tick();
      end
    end

    blink_mask = '0;
    dp_mask    = '0;
    applyStimulus(42, 1'b1, 5, 77, cycles);
    check("ignoredLoadBusy", 64'(cycles), 64'd21);
    check("ignoredLoadHex", 64'(hex_out), 64'(48'hFFFF_FFFF_99A4));
    check("ignoredLoadIdle", 64'(busy), 64'd0);

    applyStimulus(1000000, 1'b0, -1, 0, cycles);
    check("preResetOvf", 64'(overflow), 64'd1);
    value_in = VW'(555);
    load     = 1'b1;
    tick();
    load     = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    tick();
    check("midResetHex", 64'(hex_out), 64'(48'hFFFF_FFFF_FFFF));
    check("midResetBusy", 64'(busy), 64'd0);
    check("midResetOvf", 64'(overflow), 64'd0);
    rst    = 1'b0;
    mValid = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      check("postResetBusy", 64'(busy), 64'd0);
      checkOutput("postResetHex");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
